// File: rtl/parking_gate_ctrl_if.sv
// Sensor-pulse inputs and gate/occupancy status outputs of the parking gate controller.
// The master modport is the sensor/display side; the slave modport is the controller.
interface parking_gate_ctrl_if #(
    parameter int CNT_W = 4
);
    logic             entry_pulse;
    logic             exit_pulse;
    logic             gate_open;
    logic             gate_dir;
    logic [CNT_W-1:0] occupied;
    logic [CNT_W-1:0] free_spaces;
    logic             full;
    logic             empty;
    logic             entry_grant;
    logic             exit_grant;
    logic             entry_reject;
    logic             overrun;

    modport master (
        output entry_pulse, exit_pulse,
        input  gate_open, gate_dir, occupied, free_spaces, full, empty,
               entry_grant, exit_grant, entry_reject, overrun
    );

    modport slave (
        input  entry_pulse, exit_pulse,
        output gate_open, gate_dir, occupied, free_spaces, full, empty,
               entry_grant, exit_grant, entry_reject, overrun
    );
endinterface

// File: rtl/parking_gate_ctrl.sv
// Occupancy counter and single-barrier gate FSM; one pending request per direction
// is held while the gate is busy, and exits take priority over entries.
module parking_gate_ctrl #(
    parameter int CAPACITY    = 8,
    parameter int OPEN_CYCLES = 4,
    parameter int CNT_W       = 4,
    parameter int TMR_W       = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    parking_gate_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ENTRY_OPEN, EXIT_OPEN} state_t;

    localparam logic [CNT_W-1:0] CAP_C  = CNT_W'(CAPACITY);
    localparam logic [TMR_W-1:0] TMR_LD = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic             pend_entry, pend_exit;
    logic             gate_open, gate_dir, full, empty;
    logic             entry_grant, exit_grant, entry_reject, overrun;
    logic [CNT_W-1:0] occupied, free_spaces;

    logic req_exit, req_entry, exit_ok;
    assign req_exit  = bus.exit_pulse  | pend_exit;
    assign req_entry = bus.entry_pulse | pend_entry;
    assign exit_ok   = req_exit & ~empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            timer        <= '0;
            pend_entry   <= 1'b0;
            pend_exit    <= 1'b0;
            gate_open    <= 1'b0;
            gate_dir     <= 1'b0;
            occupied     <= '0;
            free_spaces  <= CAP_C;
            full         <= 1'b0;
            empty        <= 1'b1;
            entry_grant  <= 1'b0;
            exit_grant   <= 1'b0;
            entry_reject <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            entry_grant  <= 1'b0;
            exit_grant   <= 1'b0;
            entry_reject <= 1'b0;
            overrun      <= 1'b0;
            case (state)
                IDLE: begin
                    // An exit on an empty lot is dropped silently.
                    if (req_exit) begin
                        pend_exit <= 1'b0;
                        if (!empty) begin
                            state       <= EXIT_OPEN;
                            timer       <= TMR_LD;
                            gate_open   <= 1'b1;
                            gate_dir    <= 1'b0;
                            exit_grant  <= 1'b1;
                            occupied    <= occupied - ONE;
                            free_spaces <= free_spaces + ONE;
                            full        <= 1'b0;
                            empty       <= (occupied == ONE);
                        end
                    end
                    // An entry that loses to an exit waits; it is judged against
                    // fullness only once it is actually served.
                    if (req_entry) begin
                        if (exit_ok) begin
                            pend_entry <= 1'b1;
                        end else if (!full) begin
                            state       <= ENTRY_OPEN;
                            timer       <= TMR_LD;
                            gate_open   <= 1'b1;
                            gate_dir    <= 1'b1;
                            entry_grant <= 1'b1;
                            pend_entry  <= 1'b0;
                            occupied    <= occupied + ONE;
                            free_spaces <= free_spaces - ONE;
                            full        <= (occupied + ONE == CAP_C);
                            empty       <= 1'b0;
                        end else begin
                            entry_reject <= 1'b1;
                            pend_entry   <= 1'b0;
                        end
                    end
                end
                default: begin
                    pend_entry <= pend_entry | bus.entry_pulse;
                    pend_exit  <= pend_exit  | bus.exit_pulse;
                    overrun    <= (pend_entry & bus.entry_pulse) | (pend_exit & bus.exit_pulse);
                    if (timer != '0) begin
                        timer <= timer - TMR_W'(1);
                    end else begin
                        state     <= IDLE;
                        gate_open <= 1'b0;
                        gate_dir  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.gate_open    = gate_open;
    assign bus.gate_dir     = gate_dir;
    assign bus.occupied     = occupied;
    assign bus.free_spaces  = free_spaces;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.entry_grant  = entry_grant;
    assign bus.exit_grant   = exit_grant;
    assign bus.entry_reject = entry_reject;
    assign bus.overrun      = overrun;
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Bench for parking_gate_ctrl: directed scenarios plus random pulses against a
// timestamp-based occupancy/gate model.
module tb_parking_gate_ctrl;
    localparam int CAP = 2;
    localparam int OC  = 3;
    localparam int CW  = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [15:0] exp_v;

    parking_gate_ctrl_if #(.CNT_W(CW)) bus ();

    parking_gate_ctrl #(.CAPACITY(CAP), .OPEN_CYCLES(OC), .CNT_W(CW), .TMR_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Observed vector: {open, dir, occupied, free, full, empty, eg, xg, rej, ovr}
    function automatic logic [15:0] outs();
        return {bus.gate_open, bus.gate_dir, bus.occupied, bus.free_spaces, bus.full, bus.empty,
                bus.entry_grant, bus.exit_grant, bus.entry_reject, bus.overrun};
    endfunction

    function automatic logic [15:0] pack(bit go, bit gd, int occ, bit eg, bit xg, bit rj, bit ov);
        logic [3:0] o4, f4;
        o4 = 4'(occ);
        f4 = 4'(CAP - occ);
        return {go, gd, o4, f4, (occ == CAP), (occ == 0), eg, xg, rj, ov};
    endfunction

    // Apply pulses for one edge, then settle 1 time unit after it.
    task automatic step(input bit e, input bit x);
        bus.entry_pulse = e;
        bus.exit_pulse  = x;
        @(posedge clk);
        #1;
        bus.entry_pulse = 1'b0;
        bus.exit_pulse  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(0, 0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        exp_v = pack(0, 0, 0, 0, 0, 0, 0); checks++;
        if (outs() !== exp_v) begin errors++; $display("FAIL reset_state got=%b exp=%b", outs(), exp_v); end
    endtask

    task automatic test_single_entry();
        do_reset();
        step(1, 0);
        exp_v = pack(1, 1, 1, 1, 0, 0, 0); checks++;
        if (outs() !== exp_v) begin errors++; $display("FAIL single_entry_grant got=%b exp=%b", outs(), exp_v); end
        for (int i = 0; i < OC - 1; i++) begin
            step(0, 0);
            exp_v = pack(1, 1, 1, 0, 0, 0, 0); checks++;
            if (outs() !== exp_v) begin errors++; $display("FAIL single_entry_open%0d got=%b exp=%b", i, outs(), exp_v); end
        end
        step(0, 0);
        exp_v = pack(0, 0, 1, 0, 0, 0, 0); checks++;
        if (outs() !== exp_v) begin errors++; $display("FAIL single_entry_close got=%b exp=%b", outs(), exp_v); end
    endtask

    task automatic test_fill_reject();
        do_reset();
        step(1, 0); repeat (OC) step(0, 0);
        step(1, 0);
        exp_v = pack(1, 1, 2, 1, 0, 0, 0); checks++;
        if (outs() !== exp_v) begin errors++; $display("FAIL fill_second_grant got=%b exp=%b", outs(), exp_v); end
        repeat (OC) step(0, 0);
        step(1, 0);
        exp_v = pack(0, 0, 2, 0, 0, 1, 0); checks++;
        if (outs() !== exp_v) begin errors++; $display("FAIL fill_reject got=%b exp=%b", outs(), exp_v); end
        step(0, 0);
        exp_v = pack(0, 0, 2, 0, 0, 0, 0); checks++;
        if (outs() !== exp_v) begin errors++; $display("FAIL fill_after_reject got=%b exp=%b", outs(), exp_v); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        step(1, 0); repeat (OC) step(0, 0);
        step(1, 1);
        exp_v = pack(1, 0, 0, 0, 1, 0, 0); checks++;
        if (outs() !== exp_v) begin errors++; $display("FAIL simul_exit_first got=%b exp=%b", outs(), exp_v); end
        repeat (OC) step(0, 0);
        exp_v = pack(0, 0, 0, 0, 0, 0, 0); checks++;
        if (outs() !== exp_v) begin errors++; $display("FAIL simul_closed_gap got=%b exp=%b", outs(), exp_v); end
        step(0, 0);
        exp_v = pack(1, 1, 1, 1, 0, 0, 0); checks++;
        if (outs() !== exp_v) begin errors++; $display("FAIL simul_entry_served got=%b exp=%b", outs(), exp_v); end
    endtask

    task automatic test_overrun();
        int grants;
        do_reset();
        step(1, 0);
        step(0, 1);
        exp_v = pack(1, 1, 1, 0, 0, 0, 0); checks++;
        if (outs() !== exp_v) begin errors++; $display("FAIL overrun_first_pend got=%b exp=%b", outs(), exp_v); end
        step(0, 1);
        exp_v = pack(1, 1, 1, 0, 0, 0, 1); checks++;
        if (outs() !== exp_v) begin errors++; $display("FAIL overrun_pulse got=%b exp=%b", outs(), exp_v); end
        step(0, 0);
        exp_v = pack(0, 0, 1, 0, 0, 0, 0); checks++;
        if (outs() !== exp_v) begin errors++; $display("FAIL overrun_closed got=%b exp=%b", outs(), exp_v); end
        step(0, 0);
        exp_v = pack(1, 0, 0, 0, 1, 0, 0); checks++;
        if (outs() !== exp_v) begin errors++; $display("FAIL overrun_exit_grant got=%b exp=%b", outs(), exp_v); end
        grants = 0;
        repeat (2 * OC + 2) begin
            step(0, 0);
            grants += int'(bus.exit_grant);
        end
        checks++;
        if (grants !== 0) begin errors++; $display("FAIL overrun_single_exit extra_grants=%0d exp=0", grants); end
    endtask

    task automatic test_exit_empty();
        do_reset();
        step(0, 1);
        exp_v = pack(0, 0, 0, 0, 0, 0, 0); checks++;
        if (outs() !== exp_v) begin errors++; $display("FAIL exit_empty_ignored got=%b exp=%b", outs(), exp_v); end
        step(0, 0);
        exp_v = pack(0, 0, 0, 0, 0, 0, 0); checks++;
        if (outs() !== exp_v) begin errors++; $display("FAIL exit_empty_after got=%b exp=%b", outs(), exp_v); end
    endtask

    task automatic test_reset_mid_open();
        do_reset();
        step(1, 0);
        step(1, 0);
        reset = 1'b1;
        step(1, 0);
        reset = 1'b0;
        exp_v = pack(0, 0, 0, 0, 0, 0, 0); checks++;
        if (outs() !== exp_v) begin errors++; $display("FAIL reset_mid_open got=%b exp=%b", outs(), exp_v); end
        // A surviving pend_entry would be granted on this idle edge.
        step(0, 0);
        exp_v = pack(0, 0, 0, 0, 0, 0, 0); checks++;
        if (outs() !== exp_v) begin errors++; $display("FAIL reset_pend_cleared got=%b exp=%b", outs(), exp_v); end
    endtask

    // Reference: the gate is open after edges [grant, grant+OC) and the controller
    // accepts new requests only on edges strictly after grant+OC.
    task automatic test_random();
        int  n, close_at, occ;
        bit  pe, px, dir, e, x, r, eg, xg, rj, ov, go, rx, re;
        int  bad;
        bad = 0;
        n = 0; close_at = 0; occ = 0; pe = 0; px = 0; dir = 0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            e = ($urandom_range(0, 3) == 0);
            x = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 59) == 0);
            n++;
            eg = 0; xg = 0; rj = 0; ov = 0;
            if (r) begin
                occ = 0; pe = 0; px = 0; close_at = n;
            end else if (n > close_at) begin
                rx = x | px; re = e | pe;
                if (rx) begin
                    px = 0;
                    if (occ > 0) begin occ--; xg = 1; close_at = n + OC; dir = 0; end
                end
                if (re) begin
                    if (xg) pe = 1;
                    else if (occ < CAP) begin occ++; eg = 1; pe = 0; close_at = n + OC; dir = 1; end
                    else begin rj = 1; pe = 0; end
                end
            end else begin
                ov = (e & pe) | (x & px);
                pe |= e; px |= x;
            end
            go = (n < close_at);
            reset = r;
            step(e, x);
            reset = 1'b0;
            exp_v = pack(go, go & dir, occ, eg, xg, rj, ov); checks++;
            if (outs() !== exp_v) begin
                errors++;
                if (bad++ < 10) $display("FAIL random_cyc%0d got=%b exp=%b", c, outs(), exp_v);
            end
        end
    endtask

    initial begin
        bus.entry_pulse = 1'b0;
        bus.exit_pulse  = 1'b0;
        test_reset();
        test_single_entry();
        test_fill_reject();
        test_simultaneous();
        test_overrun();
        test_exit_empty();
        test_reset_mid_open();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
